// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode/EXE status in, pipeline register controls out
//
// Groups the signals exchanged between the pipeline datapath and the hazard controller.
//   master : pipeline datapath. Drives decode register numbers and EXE status, consumes the controls.
//   slave  : hazard controller. Consumes the status, drives pc/IF_ID/ID_EXE/EXE_MEM controls.
interface pipeline_hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_use_rs;
  logic       ID_use_rt;
  logic       ID_is_muldiv;
  logic       EXE_mem_read;
  logic       EXE_reg_write;
  logic [4:0] EXE_num_write;
  logic       branch_taken;

  logic       pc_write;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       ID_EXE_bubble;
  logic       ID_EXE_hold;
  logic       EXE_MEM_bubble;
  logic       md_busy;

  modport master (
    output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_muldiv,
    output EXE_mem_read, EXE_reg_write, EXE_num_write, branch_taken,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EXE_bubble, ID_EXE_hold,
    input  EXE_MEM_bubble, md_busy
  );

  modport slave (
    input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_muldiv,
    input  EXE_mem_read, EXE_reg_write, EXE_num_write, branch_taken,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EXE_bubble, ID_EXE_hold,
    output EXE_MEM_bubble, md_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage MIPS pipeline
//
// Handles load-use stalls, taken-branch flushes and multi-cycle mul/div occupancy of EXE.
// All controls are combinational from the current state and inputs and act on the edge
// that ends the current cycle.
//
// Ports:
//   clock        pipeline clock
//   reset        synchronous, active-high; returns the FSM to RUN and clears counters
//   hif          pipeline_hazard_ctrl_if.slave (decode/EXE status in, register controls out)
//   stall_count  [CNT_W-1:0] saturating count of cycles with pc_write=0
//                (present only when PIPE_STALL_CNT_EN is defined)
//
// Parameters:
//   MD_LATENCY   total EXE cycles of a mul/div op, 1..15 (1 = no busy state)
//   CNT_W        stall_count width (only when PIPE_STALL_CNT_EN is defined)
//
// Optional feature macro: PIPE_STALL_CNT_EN
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4
`ifdef PIPE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hif
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0]    stall_count
`endif
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic lu_hazard;
  logic pc_write, if_id_write, if_id_flush;
  logic id_exe_bubble, id_exe_hold, exe_mem_bubble, md_busy;

  // $0 is hard-wired, so a load targeting it can never feed a consumer.
  assign lu_hazard = hif.EXE_mem_read && hif.EXE_reg_write && (hif.EXE_num_write != 5'd0) &&
                     ((hif.ID_use_rs && (hif.ID_rs == hif.EXE_num_write)) ||
                      (hif.ID_use_rt && (hif.ID_rt == hif.EXE_num_write)));

  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_exe_bubble  = 1'b0;
    id_exe_hold    = 1'b0;
    exe_mem_bubble = 1'b0;
    md_busy        = 1'b0;
    state_d        = state_q;
    md_cnt_d       = md_cnt_q;

    // While reset is high the outputs stay at their free-running values.
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (hif.branch_taken) begin
            // ID holds a wrong-path instruction: squash it, ignore its hazards.
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
          end else if (lu_hazard) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
          end else if (hif.ID_is_muldiv && (MD_LATENCY > 1)) begin
            // The op advances into EXE normally this cycle, then EXE is held.
            state_d  = MD_BUSY;
            md_cnt_d = 4'(MD_LATENCY - 1);
          end
        end
        MD_BUSY: begin
          pc_write       = 1'b0;
          if_id_write    = 1'b0;
          id_exe_hold    = 1'b1;
          exe_mem_bubble = 1'b1;
          md_busy        = 1'b1;
          md_cnt_d       = md_cnt_q - 4'd1;
          if (md_cnt_q == 4'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hif.pc_write       = pc_write;
  assign hif.IF_ID_write    = if_id_write;
  assign hif.IF_ID_flush    = if_id_flush;
  assign hif.ID_EXE_bubble  = id_exe_bubble;
  assign hif.ID_EXE_hold    = id_exe_hold;
  assign hif.EXE_MEM_bubble = exe_mem_bubble;
  assign hif.md_busy        = md_busy;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enables and bubble controls of the PC, IF_ID, ID_EXE and EXE_MEM registers. It handles three events: load-use hazards, taken-branch flushes, and multi-cycle mul/div occupancy of EXE.
- Sits beside the decode stage. It takes decode register numbers and EXE-stage status, and returns per-cycle pipeline control.

Parameters:
- MD_LATENCY, 4, total EXE cycles of a mul/div op (legal range 1..15; 1 = single-cycle, no busy state).
- CNT_W, 16, width of stall_count (optional feature only).

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high; clears the FSM and counters
- ID_rs  in  5  rs number of the instruction in ID
- ID_rt  in  5  rt number of the instruction in ID
- ID_use_rs  in  1  ID instruction reads rs
- ID_use_rt  in  1  ID instruction reads rt
- ID_is_muldiv  in  1  ID instruction is a multi-cycle mul/div
- EXE_mem_read  in  1  instruction in EXE is a load
- EXE_reg_write  in  1  instruction in EXE writes the register file
- EXE_num_write  in  5  destination register of the EXE instruction
- branch_taken  in  1  branch/jump resolved taken in EXE this cycle
- pc_write  out  1  1 = PC loads its next value
- IF_ID_write  out  1  1 = IF_ID captures; 0 = hold
- IF_ID_flush  out  1  1 = IF_ID loads a nop
- ID_EXE_bubble  out  1  1 = ID_EXE loads all-zero (nop)
- ID_EXE_hold  out  1  1 = ID_EXE keeps its current contents
- EXE_MEM_bubble  out  1  1 = EXE_MEM loads a nop
- md_busy  out  1  FSM in MD_BUSY

Behaviour:
- States: RUN, MD_BUSY. A 4-bit down-counter md_cnt is used in MD_BUSY.
- reset=1 at a clock edge gives state=RUN and md_cnt=0.
- During reset all outputs take their RUN/no-hazard values: pc_write=1, IF_ID_write=1, all flush/bubble/hold=0, md_busy=0. Reset mid-MD_BUSY aborts to RUN on that edge.
- lu_hazard (combinational) = EXE_mem_read & EXE_reg_write & (EXE_num_write != 0) & ((ID_use_rs & ID_rs == EXE_num_write) | (ID_use_rt & ID_rt == EXE_num_write)).
- All outputs are combinational from the current state and inputs. Zero latency: they act on the edge ending the current cycle.
- RUN, priority 1, branch_taken=1:
  - IF_ID_flush=1, ID_EXE_bubble=1, pc_write=1 (target loads), IF_ID_write=1.
  - lu_hazard and ID_is_muldiv are ignored; the ID instruction is wrong-path.
  - Stay in RUN.
- RUN, priority 2, lu_hazard=1:
  - pc_write=0, IF_ID_write=0, ID_EXE_bubble=1.
  - Stay in RUN. The single bubble resolves the hazard the next cycle.
- RUN, priority 3, ID_is_muldiv=1 and MD_LATENCY>1:
  - Normal advance (all enables 1).
  - Next state MD_BUSY, md_cnt <= MD_LATENCY-1.
- RUN otherwise: normal advance.
- MD_BUSY:
  - pc_write=0, IF_ID_write=0, ID_EXE_hold=1, EXE_MEM_bubble=1, md_busy=1.
  - md_cnt decrements each cycle. When md_cnt==1, next state is RUN. The last busy cycle still drives the stall outputs.
  - branch_taken and lu_hazard are ignored: a mul/div in EXE is neither a branch nor a load.
- Exclusivity:
  - ID_EXE_bubble and ID_EXE_hold are never both 1.
  - IF_ID_flush never coincides with IF_ID_write=0.
- Register $0 never causes a hazard.
- Back-to-back mul/div: the second op is seen in ID on the first RUN cycle after busy and re-enters MD_BUSY.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_count [CNT_W-1:0].
  - Increments once per cycle in which pc_write=0 (load-use or MD_BUSY).
  - Saturates at all-ones; cleared by reset.
- Undefined: port and counter are absent; no other behaviour changes.

Test Plan:
- Load-use on rs: EXE_mem_read=1, EXE_reg_write=1, EXE_num_write=8, ID_rs=8, ID_use_rs=1 -> same cycle pc_write=0, IF_ID_write=0, ID_EXE_bubble=1. Next cycle, with EXE now a bubble, normal advance.
- $0 and unused operand: EXE_num_write=0 with ID_rs=0; then EXE_num_write=9 with ID_rt=9 and ID_use_rt=0 -> no stall in either case.
- Branch over hazard: branch_taken=1 together with a lu_hazard condition -> IF_ID_flush=1, ID_EXE_bubble=1, pc_write=1, IF_ID_write=1.
- Mul/div, MD_LATENCY=4: ID_is_muldiv=1 in RUN -> exactly 3 following cycles with md_busy=1, ID_EXE_hold=1, EXE_MEM_bubble=1, pc_write=0, then RUN. Repeat with MD_LATENCY=1 -> md_busy never asserts.
- Reset mid-busy: assert reset on the 2nd MD_BUSY cycle -> next cycle state=RUN, md_busy=0, pc_write=1. stall_count=0 if PIPE_STALL_CNT_EN is defined.
- Counter (PIPE_STALL_CNT_EN, CNT_W=2): 5 stall cycles -> stall_count reads 1, 2, 3, 3, 3 (saturates).
